// File: rtl/gnn_pkg.sv
// rtl/gnn_pkg.sv - shared widths, aggregator state encoding and feature vector type
package gnn_pkg;

  localparam int FEAT_SIZE   = 5;
  localparam int MAC_IN_SIZE = 5;
  localparam int MAX_NBR     = 16;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    EMIT  = 2'd1,
    DRAIN = 2'd2
  } agg_state_t;

  typedef logic signed [FEAT_SIZE-1:0] feat_t;
  typedef feat_t [3:0] feat_vec_t;

endpackage

// File: rtl/agg_lane.sv
// rtl/agg_lane.sv - one signed accumulator lane with saturating clamp to the MAC width
module agg_lane #(
  parameter int FEAT_SIZE   = gnn_pkg::FEAT_SIZE,
  parameter int MAC_IN_SIZE = gnn_pkg::MAC_IN_SIZE,
  parameter int ACC_SIZE    = gnn_pkg::FEAT_SIZE + $clog2(gnn_pkg::MAX_NBR)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          add,
  input  logic signed [FEAT_SIZE-1:0]   f,
  output logic signed [MAC_IN_SIZE-1:0] x,
  output logic                          clamped
);

  localparam logic signed [ACC_SIZE-1:0] HI = ACC_SIZE'((2 ** (MAC_IN_SIZE - 1)) - 1);
  localparam logic signed [ACC_SIZE-1:0] LO = ACC_SIZE'(-(2 ** (MAC_IN_SIZE - 1)));

  logic signed [ACC_SIZE-1:0] acc;

  // Accumulate sign-extended features; clear wins over add.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (add) begin
      acc <= acc + {{(ACC_SIZE - FEAT_SIZE){f[FEAT_SIZE-1]}}, f};
    end
  end

  // Saturate the running sum into the MAC input range and flag any clamp.
  always_comb begin
    clamped = 1'b0;
    x       = acc[MAC_IN_SIZE-1:0];
    if (acc > HI) begin
      x       = HI[MAC_IN_SIZE-1:0];
      clamped = 1'b1;
    end else if (acc < LO) begin
      x       = LO[MAC_IN_SIZE-1:0];
      clamped = 1'b1;
    end
  end

endmodule

// File: rtl/feature_aggregator.sv
// rtl/feature_aggregator.sv - per-node neighbour feature summation feeding the MAC
module feature_aggregator #(
  parameter int FEAT_SIZE   = gnn_pkg::FEAT_SIZE,
  parameter int MAC_IN_SIZE = gnn_pkg::MAC_IN_SIZE,
  parameter int MAX_NBR     = gnn_pkg::MAX_NBR,
  parameter int ACC_SIZE    = FEAT_SIZE + $clog2(MAX_NBR),
  parameter int CNT_SIZE    = $clog2(MAX_NBR) + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          nbr_valid,
  output logic                          nbr_ready,
  input  logic                          nbr_last,
  input  logic signed [FEAT_SIZE-1:0]   f0,
  input  logic signed [FEAT_SIZE-1:0]   f1,
  input  logic signed [FEAT_SIZE-1:0]   f2,
  input  logic signed [FEAT_SIZE-1:0]   f3,
  output logic signed [MAC_IN_SIZE-1:0] x0,
  output logic signed [MAC_IN_SIZE-1:0] x1,
  output logic signed [MAC_IN_SIZE-1:0] x2,
  output logic signed [MAC_IN_SIZE-1:0] x3,
  output logic                          in_ready,
  output logic [CNT_SIZE-1:0]           nbr_count,
  output logic                          sat,
  output logic                          len_err
);

  import gnn_pkg::*;

  agg_state_t          state, state_nxt;
  logic [CNT_SIZE-1:0] cnt;
  logic                force_q;
  logic                accept;
  logic                at_limit;
  logic                lane_add;
  logic                lane_clr;

  logic signed [FEAT_SIZE-1:0]   f_lane     [4];
  logic signed [MAC_IN_SIZE-1:0] x_lane     [4];
  logic                          clamp_lane [4];

  assign f_lane[0] = f0;
  assign f_lane[1] = f1;
  assign f_lane[2] = f2;
  assign f_lane[3] = f3;

  // Ready is a pure state decode: only the single EMIT cycle stalls the stream.
  always_comb begin
    nbr_ready = (state != EMIT);
  end

  assign accept   = nbr_valid && nbr_ready;
  assign at_limit = (cnt == CNT_SIZE'(MAX_NBR - 1));
  assign lane_add = accept && (state == ACCUM);
  assign lane_clr = (state == EMIT);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    agg_lane #(
      .FEAT_SIZE  (FEAT_SIZE),
      .MAC_IN_SIZE(MAC_IN_SIZE),
      .ACC_SIZE   (ACC_SIZE)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (lane_clr),
      .add    (lane_add),
      .f      (f_lane[i]),
      .x      (x_lane[i]),
      .clamped(clamp_lane[i])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  // Next state: close on last or at the neighbour limit; a forced close drains the rest.
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (accept && (nbr_last || at_limit)) state_nxt = EMIT;
      EMIT:    state_nxt = force_q ? DRAIN : ACCUM;
      DRAIN:   if (accept && nbr_last) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // Beat count and forced-close flag for the node being accumulated.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      force_q <= 1'b0;
    end else if (state == EMIT) begin
      cnt     <= '0;
      force_q <= 1'b0;
    end else if (lane_add) begin
      cnt <= cnt + 1'b1;
      if (at_limit && !nbr_last) force_q <= 1'b1;
    end
  end

  // Capture the node result during EMIT; it holds until the next node closes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x0        <= '0;
      x1        <= '0;
      x2        <= '0;
      x3        <= '0;
      nbr_count <= '0;
      sat       <= 1'b0;
      len_err   <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      in_ready <= (state == EMIT);
      if (state == EMIT) begin
        x0        <= x_lane[0];
        x1        <= x_lane[1];
        x2        <= x_lane[2];
        x3        <= x_lane[3];
        nbr_count <= cnt;
        sat       <= clamp_lane[0] | clamp_lane[1] | clamp_lane[2] | clamp_lane[3];
        len_err   <= force_q;
      end
    end
  end

endmodule

// File: tb/tb_feature_aggregator.sv
// tb/tb_feature_aggregator.sv - scoreboard bench for feature_aggregator
module tb_feature_aggregator;

  import gnn_pkg::*;

  localparam int MAXN = gnn_pkg::MAX_NBR;
  localparam int XHI  = (2 ** (gnn_pkg::MAC_IN_SIZE - 1)) - 1;
  localparam int XLO  = -(2 ** (gnn_pkg::MAC_IN_SIZE - 1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic nbr_valid = 1'b0;
  logic nbr_last = 1'b0;
  logic nbr_ready;
  logic signed [FEAT_SIZE-1:0] f0 = '0, f1 = '0, f2 = '0, f3 = '0;
  logic signed [MAC_IN_SIZE-1:0] x0, x1, x2, x3;
  logic in_ready, sat, len_err;
  logic [$clog2(MAXN):0] nbr_count;

  feature_aggregator dut (
    .clk(clk), .rst_n(rst_n), .nbr_valid(nbr_valid), .nbr_ready(nbr_ready),
    .nbr_last(nbr_last), .f0(f0), .f1(f1), .f2(f2), .f3(f3),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .in_ready(in_ready),
    .nbr_count(nbr_count), .sat(sat), .len_err(len_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  typedef struct {
    int x[4];
    int cnt;
    int sat;
    int len;
  } exp_t;

  exp_t      q[$];
  feat_vec_t beats[32];
  bit        streaming = 1'b0;
  int        last_strobe = -1;
  int        strobes = 0;
  int        emit_lows = 0;

  // Monitor: every in_ready strobe is matched against the oldest expected node.
  always @(negedge clk) begin
    exp_t e;
    if (streaming && rst_n && !nbr_ready) emit_lows++;
    if (rst_n && in_ready) begin
      strobes++;
      if (streaming && last_strobe >= 0) chk("strobe_spacing", cyc - last_strobe, 2);
      last_strobe = cyc;
      if (q.size() == 0) begin
        chk("unexpected_in_ready", 1, 0);
      end else begin
        e = q.pop_front();
        chk("x0", int'(x0), e.x[0]);
        chk("x1", int'(x1), e.x[1]);
        chk("x2", int'(x2), e.x[2]);
        chk("x3", int'(x3), e.x[3]);
        chk("nbr_count", int'(nbr_count), e.cnt);
        chk("sat", int'(sat), e.sat);
        chk("len_err", int'(len_err), e.len);
      end
    end
  end

  function automatic feat_vec_t mk(input int a, input int b, input int c, input int d);
    feat_vec_t v;
    v[0] = FEAT_SIZE'(a);
    v[1] = FEAT_SIZE'(b);
    v[2] = FEAT_SIZE'(c);
    v[3] = FEAT_SIZE'(d);
    return v;
  endfunction

  function automatic int clampv(input int s);
    if (s > XHI) return XHI;
    if (s < XLO) return XLO;
    return s;
  endfunction

  // Reference: sum the first min(k, MAXN) beats, saturate, flag overlong nodes.
  task automatic push_expected(input int k);
    exp_t e;
    int n;
    int s;
    n = (k > MAXN) ? MAXN : k;
    e.sat = 0;
    for (int l = 0; l < 4; l++) begin
      s = 0;
      for (int b = 0; b < n; b++) s += int'($signed(beats[b][l]));
      e.x[l] = clampv(s);
      if (e.x[l] != s) e.sat = 1;
    end
    e.cnt = n;
    e.len = (k > MAXN) ? 1 : 0;
    q.push_back(e);
  endtask

  // Present one beat and hold it until a cycle with nbr_ready high has passed.
  task automatic send_beat(input feat_vec_t v, input bit last);
    bit rdy;
    bit done;
    int n;
    n = 0;
    done = 1'b0;
    nbr_valid = 1'b1;
    nbr_last = last;
    f0 = v[0]; f1 = v[1]; f2 = v[2]; f3 = v[3];
    while (!done) begin
      @(negedge clk);
      rdy = nbr_ready;
      @(posedge clk);
      #1;
      if (rdy) done = 1'b1;
      else begin
        n++;
        if (n > 40) begin
          chk("beat_accept_timeout", 0, 1);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic run_node(input int k, input bit gaps, input bit keep);
    push_expected(k);
    for (int b = 0; b < k; b++) begin
      send_beat(beats[b], b == k - 1);
      if (gaps && $urandom_range(0, 3) == 0 && b != k - 1) begin
        nbr_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
    if (!keep) nbr_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0;
    int k;

    // Reset and idle.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_x0", int'(x0), 0);
    chk("rst_x1", int'(x1), 0);
    chk("rst_x2", int'(x2), 0);
    chk("rst_x3", int'(x3), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_nbr_count", int'(nbr_count), 0);
    chk("rst_sat", int'(sat), 0);
    chk("rst_len_err", int'(len_err), 0);
    chk("rst_nbr_ready", int'(nbr_ready), 1);
    @(posedge clk); #1;

    // Reset mid-node with a last beat presented during the reset cycle.
    send_beat(mk(5, 5, 5, 5), 1'b0);
    send_beat(mk(7, 1, 1, 1), 1'b0);
    nbr_valid = 1'b1;
    nbr_last = 1'b1;
    f0 = 5'sd9; f1 = 5'sd9; f2 = 5'sd9; f3 = 5'sd9;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    nbr_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", int'(nbr_ready), 1);
    @(posedge clk); #1;
    beats[0] = mk(3, 0, 0, 0);
    run_node(1, 1'b0, 1'b0);
    repeat (3) @(posedge clk); #1;

    // Three-beat node with cycle-exact ready/strobe timing.
    beats[0] = mk(1, 2, 3, 4);
    beats[1] = mk(2, 2, 2, 2);
    beats[2] = mk(-1, 0, 1, -5);
    run_node(3, 1'b0, 1'b0);
    @(negedge clk);
    chk("emit_nbr_ready", int'(nbr_ready), 0);
    chk("emit_in_ready", int'(in_ready), 0);
    @(negedge clk);
    chk("n2_in_ready", int'(in_ready), 1);
    chk("n2_nbr_ready", int'(nbr_ready), 1);
    @(negedge clk);
    chk("strobe_one_cycle", int'(in_ready), 0);
    @(posedge clk); #1;

    // Saturation on both rails.
    for (int b = 0; b < 4; b++) beats[b] = mk(15, -16, 8, 0);
    run_node(4, 1'b0, 1'b0);
    repeat (3) @(posedge clk); #1;

    // Overlong node forced closed at MAX_NBR, tail dropped, then a normal node.
    beats[0] = mk(1, 0, 0, 0);
    for (int b = 1; b < 20; b++) beats[b] = mk(0, 0, 0, 0);
    run_node(20, 1'b0, 1'b0);
    beats[0] = mk(2, 2, 2, 2);
    run_node(1, 1'b0, 1'b0);
    repeat (3) @(posedge clk); #1;

    // Exactly MAX_NBR beats closing normally, at the negative accumulator extreme.
    for (int b = 0; b < MAXN; b++) beats[b] = mk(-16, -16, 15, 1);
    run_node(MAXN, 1'b0, 1'b0);
    repeat (3) @(posedge clk); #1;

    // Back-to-back single-beat nodes with valid held high.
    s0 = strobes;
    last_strobe = -1;
    emit_lows = 0;
    streaming = 1'b1;
    for (int i = 0; i < 8; i++) begin
      beats[0] = mk(i, i, -i, i);
      run_node(1, 1'b0, 1'b1);
    end
    nbr_valid = 1'b0;
    repeat (3) @(negedge clk);
    streaming = 1'b0;
    chk("stream_strobes", strobes - s0, 8);
    chk("stream_emit_cycles", emit_lows, 8);
    @(posedge clk); #1;

    // Randomised nodes, including overlong ones and idle gaps.
    for (int n = 0; n < 30; n++) begin
      k = ($urandom_range(0, 4) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(1, 6));
      for (int b = 0; b < k; b++)
        beats[b] = mk($urandom_range(0, 31), $urandom_range(0, 31),
                      $urandom_range(0, 31), $urandom_range(0, 31));
      run_node(k, 1'b1, 1'b0);
      if ($urandom_range(0, 1) == 0) begin
        @(posedge clk); #1;
      end
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
